// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the program loader.
//   CPU_DATA_W : instruction word width
//   CPU_ADDR_W : program address width (matches the 10-bit PC/stack entries)
//   ld_state_t : program loader FSM state encoding
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 10;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2,
    LD_ERR  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Bus bundle between the host instruction stream, the program loader, the
// program memory write port and the CPU reset/status lines.
//   master : host side (drives start and the stream, observes status/writes)
//   slave  : loader side
// Stream handshake: a word transfers on a rising clk edge where
// in_valid && in_ready are both 1. While in_valid=1 and in_ready=0 the source
// holds in_data/in_last stable; in_data/in_last are ignored when no transfer
// happens. in_ready does not depend on in_valid.
interface prog_loader_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
);

  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] checksum;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error,
           count, checksum
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error,
           count, checksum
  );

endinterface

// File: rtl/prog_loader.sv
// Program loader: writes a stream of instruction words into program memory
// at consecutive addresses starting from 0 and keeps the CPU in reset until
// a complete program (terminated by in_last) has landed.
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high reset
//   bus     : prog_loader_if.slave (start, stream in, memory write port,
//             cpu_hold, done, error, count, checksum)
//   o_state : current FSM state (debug visibility)
module prog_loader
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DEPTH  = 1 << CPU_ADDR_W
) (
  input  logic       clk,
  input  logic       reset,
  prog_loader_if.slave bus,
  output ld_state_t  o_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ld_state_t         r_state;
  ld_state_t         w_next_state;
  logic              w_accept;
  logic              w_restart;

  logic [ADDR_W-1:0] r_addr;      // next write index
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_checksum;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  // Next-state logic. start is only honoured outside LOAD, so a stray pulse
  // mid-load cannot rewind the address.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (bus.start) begin
          w_restart    = 1'b1;
          w_next_state = LD_LOAD;
        end
      end
      LD_LOAD: begin
        w_accept = bus.in_valid;
        if (w_accept) begin
          // in_last wins at the final slot: a program that exactly fills
          // the memory is a success, not an overflow.
          if (bus.in_last) begin
            w_next_state = LD_DONE;
          end else if (r_addr == LAST_ADDR) begin
            w_next_state = LD_ERR;
          end
        end
      end
      default: w_next_state = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LD_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Write-port register stage. count/checksum update on the same edge that
  // raises mem_we, so they describe exactly the words written so far.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_count     <= '0;
      r_checksum  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_accept;
      if (w_accept) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= bus.in_data;
        r_addr      <= r_addr + ADDR_W'(1);
        r_count     <= r_count + (ADDR_W + 1)'(1);
        r_checksum  <= r_checksum ^ bus.in_data;
      end else if (w_restart) begin
        r_addr     <= '0;
        r_count    <= '0;
        r_checksum <= '0;
      end
    end
  end

  // Status decodes from the state register: DONE is entered on the same edge
  // that issues the final write, so the CPU release coincides with it.
  assign bus.in_ready  = (r_state == LD_LOAD);
  assign bus.cpu_hold  = (r_state != LD_DONE);
  assign bus.done      = (r_state == LD_DONE);
  assign bus.error     = (r_state == LD_ERR);
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.count     = r_count;
  assign bus.checksum  = r_checksum;
  assign o_state       = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (built with DEPTH=4 so the overflow and
// full-memory boundaries are reachable with short streams).
module tb_prog_loader;
  import cpu_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] csum;
    logic              done;
    logic              error;
    logic              hold;
  } wr_t;
  localparam int W = $bits(wr_t);

  logic      clk   = 1'b0;
  logic      reset = 1'b1;
  ld_state_t state;

  prog_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [ADDR_W:0] c, input logic [DATA_W-1:0] s,
                           input logic dn, input logic er, input logic hd);
    wr_t e;
    e = '{addr: a, data: d, count: c, csum: s, done: dn, error: er, hold: hd};
    exp_q.push_back(e);
  endtask

  // Monitor: every write pulse must match the next expected record.
  always @(negedge clk) begin : monitor
    wr_t act_w;
    wr_t exp_w;
    if (bus.mem_we === 1'b1) begin
      act_w = '{addr: bus.mem_addr, data: bus.mem_wdata, count: bus.count,
                csum: bus.checksum, done: bus.done, error: bus.error, hold: bus.cpu_hold};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, expected no write (t=%0t)",
                 act_w.addr, act_w.data, $time);
      end else begin
        exp_w = exp_q.pop_front();
        if (act_w !== exp_w) begin
          failures++;
          $display("FAIL write: got addr=%0d data=%h count=%0d csum=%h done=%b err=%b hold=%b, expected addr=%0d data=%h count=%0d csum=%h done=%b err=%b hold=%b (t=%0t)",
                   act_w.addr, act_w.data, act_w.count, act_w.csum, act_w.done, act_w.error, act_w.hold,
                   exp_w.addr, exp_w.data, exp_w.count, exp_w.csum, exp_w.done, exp_w.error, exp_w.hold,
                   $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Present a word and hold it until the loader is ready; returns just after
  // the accepting edge with in_valid dropped.
  task automatic send_word(input logic [DATA_W-1:0] d, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("accept_wait", 64'(n < 20), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset values
    check("rst_cpu_hold", bus.cpu_hold, 1);
    check("rst_done",     bus.done, 0);
    check("rst_error",    bus.error, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we",   bus.mem_we, 0);
    check("rst_count",    bus.count, 0);
    check("rst_checksum", bus.checksum, 0);
    check("rst_state",    state, LD_IDLE);
    reset = 1'b0;
    tick();
    check("idle_in_ready", bus.in_ready, 0);

    // 2: three words, valid every cycle
    pulse_start();
    check("t2_state_load", state, LD_LOAD);
    check("t2_in_ready",   bus.in_ready, 1);
    expect_wr(0, 16'h1234, 1, 16'h1234, 0, 0, 1);
    expect_wr(1, 16'h00FF, 2, 16'h12CB, 0, 0, 1);
    expect_wr(2, 16'hA000, 3, 16'hB2CB, 1, 0, 0);
    send_word(16'h1234, 0);
    send_word(16'h00FF, 0);
    send_word(16'hA000, 1);
    check("t2_done",     bus.done, 1);
    check("t2_cpu_hold", bus.cpu_hold, 0);
    check("t2_count",    bus.count, 3);
    check("t2_checksum", bus.checksum, 16'hB2CB);
    tick();
    check("t2_we_pulse", bus.mem_we, 0);
    check("t2_in_ready", bus.in_ready, 0);

    // 3: word held while not ready, gaps, stray in_last during a gap
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    bus.in_last  = 1'b0;
    repeat (3) tick();
    check("t3_held_done", bus.done, 1);
    pulse_start();
    expect_wr(0, 16'h1234, 1, 16'h1234, 0, 0, 1);
    expect_wr(1, 16'h00FF, 2, 16'h12CB, 0, 0, 1);
    expect_wr(2, 16'hA000, 3, 16'hB2CB, 1, 0, 0);
    send_word(16'h1234, 0);
    bus.in_data = 16'hFFFF;
    bus.in_last = 1'b1;
    repeat (2) tick();
    bus.in_last = 1'b0;
    check("t3_gap_state", state, LD_LOAD);
    send_word(16'h00FF, 0);
    tick();
    send_word(16'hA000, 1);
    check("t3_count",    bus.count, 3);
    check("t3_checksum", bus.checksum, 16'hB2CB);
    check("t3_done",     bus.done, 1);

    // 4: overflow, five words without last into DEPTH=4
    pulse_start();
    expect_wr(0, 16'h0001, 1, 16'h0001, 0, 0, 1);
    expect_wr(1, 16'h0002, 2, 16'h0003, 0, 0, 1);
    expect_wr(2, 16'h0004, 3, 16'h0007, 0, 0, 1);
    expect_wr(3, 16'h0008, 4, 16'h000F, 0, 1, 1);
    send_word(16'h0001, 0);
    send_word(16'h0002, 0);
    send_word(16'h0004, 0);
    send_word(16'h0008, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0010;
    repeat (4) tick();
    check("t4_in_ready", bus.in_ready, 0);
    check("t4_error",    bus.error, 1);
    check("t4_cpu_hold", bus.cpu_hold, 1);
    check("t4_done",     bus.done, 0);
    check("t4_count",    bus.count, 4);
    check("t4_state",    state, LD_ERR);
    bus.in_valid = 1'b0;
    pulse_start();
    check("t4_err_clear", bus.error, 0);
    check("t4_count_clr", bus.count, 0);
    check("t4_csum_clr",  bus.checksum, 0);
    check("t4_reload",    state, LD_LOAD);
    expect_wr(0, 16'h0BAD, 1, 16'h0BAD, 1, 0, 0);
    send_word(16'h0BAD, 1);

    // 5: reset mid-load, then a full-depth reload ending at DEPTH-1
    pulse_start();
    expect_wr(0, 16'hAAAA, 1, 16'hAAAA, 0, 0, 1);
    expect_wr(1, 16'h5555, 2, 16'hFFFF, 0, 0, 1);
    send_word(16'hAAAA, 0);
    send_word(16'h5555, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5_state",     state, LD_IDLE);
    check("t5_cpu_hold",  bus.cpu_hold, 1);
    check("t5_done",      bus.done, 0);
    check("t5_count",     bus.count, 0);
    check("t5_checksum",  bus.checksum, 0);
    check("t5_mem_we",    bus.mem_we, 0);
    check("t5_mem_addr",  bus.mem_addr, 0);
    check("t5_mem_wdata", bus.mem_wdata, 0);
    check("t5_in_ready",  bus.in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    pulse_start();
    expect_wr(0, 16'h1111, 1, 16'h1111, 0, 0, 1);
    expect_wr(1, 16'h2222, 2, 16'h3333, 0, 0, 1);
    expect_wr(2, 16'h4444, 3, 16'h7777, 0, 0, 1);
    expect_wr(3, 16'h8888, 4, 16'hFFFF, 1, 0, 0);
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    send_word(16'h4444, 0);
    send_word(16'h8888, 1);
    check("t5_count4", bus.count, 4);
    check("t5_done4",  bus.done, 1);
    check("t5_error4", bus.error, 0);

    // 6: start ignored in LOAD; start in DONE begins a new load
    pulse_start();
    expect_wr(0, 16'h0100, 1, 16'h0100, 0, 0, 1);
    expect_wr(1, 16'h0200, 2, 16'h0300, 1, 0, 0);
    send_word(16'h0100, 0);
    pulse_start();
    check("t6_still_load", state, LD_LOAD);
    check("t6_count_kept", bus.count, 1);
    send_word(16'h0200, 1);
    tick();
    check("t6_done",     bus.done, 1);
    check("t6_cpu_hold", bus.cpu_hold, 0);
    pulse_start();
    check("t6_done_clr", bus.done, 0);
    check("t6_hold_set", bus.cpu_hold, 1);
    check("t6_count0",   bus.count, 0);
    check("t6_csum0",    bus.checksum, 0);
    check("t6_state",    state, LD_LOAD);
    expect_wr(0, 16'h0300, 1, 16'h0300, 1, 0, 0);
    send_word(16'h0300, 1);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion (t=%0t)", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
